// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the wait-state data-memory responder.
package dmem_responder_pkg;
    localparam int DEPTH_LOG2_DEF  = 8;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words, no reset on the array or read register.
module dmem_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [31:0] mem [2**AW];

    // Read-before-write: q shows the old word on a write edge.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the pipeline for WAIT_CYCLES+1 cycles per access,
// rejects misaligned or ambiguous requests with a one-cycle err pulse.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readmem,
    input  logic        writemem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err
);
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             q;
    logic                    valid, reject, last, we;
    logic                    unused_addr;

    assign valid  = (readmem ^ writemem) && (addr[1:0] == 2'b00);
    assign reject = (readmem | writemem) && !valid;
    assign last   = (state == BUSY) && (cnt == '0);
    assign we     = last && writemem;
    assign idx    = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2]};

    // Gated by rst so the pipeline is released the instant reset asserts.
    assign stall = rst && (((state == IDLE) && valid) || (state == BUSY));

    // Address is held stable through BUSY, so q already carries the word
    // by the final BUSY cycle and can be captured on the exit edge.
    dmem_array #(.AW(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (wdata),
        .q     (q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        state <= BUSY;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (readmem) rdata <= q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-address width (256 x 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, range 1..15, wait states inserted per access.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 readmem  input  1  load request from pipeline memory stage.
REQ-006 writemem  input  1  store request from pipeline memory stage.
REQ-007 addr  input  32  byte address of the access.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  registered load data.
REQ-010 stall  output  1  freezes the pipeline while an access is in progress.
REQ-011 err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-013 Valid request: exactly one of readmem/writemem high, and addr[1:0]==0.
REQ-014 In IDLE with a valid request, stall SHALL be 1 combinationally, the wait counter SHALL load WAIT_CYCLES-1, and the next state SHALL be BUSY.
REQ-015 In BUSY, stall SHALL be 1, the counter SHALL decrement each cycle, and the FSM SHALL move to DONE on the edge where the counter is 0.
REQ-016 The memory SHALL be accessed on the edge leaving BUSY: a write commits wdata; a read loads the word into rdata.
REQ-017 In DONE, stall SHALL be 0, and the FSM SHALL return unconditionally to IDLE on the next edge.
REQ-018 Total stall duration SHALL be exactly WAIT_CYCLES+1 cycles; rdata SHALL be valid in the DONE cycle and held until the next read.
REQ-019 The pipeline holds readmem, writemem, addr and wdata stable while stall=1; the responder SHALL sample them only when leaving BUSY.
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored (aliasing wrap-around).
REQ-021 A misaligned request (addr[1:0]!=0) in IDLE SHALL pulse err for one cycle, keep stall=0, leave memory and rdata unchanged, and keep the FSM in IDLE.
REQ-022 readmem and writemem both high in IDLE SHALL be treated as in REQ-021.
REQ-023 With no request in IDLE, stall and err SHALL be 0.
REQ-024 A request still present in the cycle after DONE SHALL be served as a new access.

Reset
REQ-025 rst low SHALL immediately force state IDLE, counter 0, stall 0, err 0, rdata 32'h0.
REQ-026 Reset asserted during BUSY SHALL abort the access; a write not yet committed SHALL NOT modify memory.
REQ-027 Memory array contents SHALL NOT be reset.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, BUSY, DONE) and the DEPTH_LOG2/WAIT_CYCLES defaults.
REQ-029 The storage SHALL be a sub-module dmem_array: a synchronous single-port RAM with one write-enable, one read port, and no reset.
REQ-030 The FSM, wait counter, error logic and rdata register SHALL reside in dmem_responder.

Verification
REQ-031 Write-then-read, WAIT_CYCLES=2: store 32'hDEADBEEF @0x10, then load @0x10 -> stall high 3 cycles each, rdata=32'hDEADBEEF in the load's DONE cycle.
REQ-032 Misaligned load @0x13 -> err pulses 1 cycle, stall stays 0, rdata unchanged.
REQ-033 readmem=writemem=1 @0x20 -> err pulse, memory @0x20 unchanged on readback.
REQ-034 Aliasing: store 32'h12345678 @0x400, load @0x0 -> rdata=32'h12345678.
REQ-035 Reset mid-write: store 32'hCAFEF00D @0x30, pull rst low in the first BUSY cycle -> stall drops immediately, later load @0x30 returns the prior value.
REQ-036 Back-to-back loads @0x4 and @0x8 -> second stall begins the cycle after DONE, each lasting WAIT_CYCLES+1 cycles with correct data.
